// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: shared MEM-stage FSM encoding, WB field indices and alignment helper.
package mips_lite_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  function automatic logic is_aligned(input logic [1:0] a);
    return (a & WORD_ALIGN_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the MEM stage and data memory.
interface mem_access_stage_if #(parameter int DATA_W = 32);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating count of cycles spent in REQ; flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = i_en && r_cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || !i_en) r_cnt <= '0;
    else if (!o_expired) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS-Lite MEM stage; req/ack data-memory access with pipeline stall.
// Define MEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES with a bus_err pulse.
module mem_access_stage
  import mips_lite_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [4:0]        wn_in,
  input  logic [1:0]        wb_in,
  output logic [DATA_W-1:0] rd_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [4:0]        wn_out,
  output logic [1:0]        wb_out,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  mem_access_stage_if.master bus
);
  state_t r_state;
  logic w_access, w_aligned, w_start, w_expired;
  assign w_access  = mem_read | mem_write;
  assign w_aligned = is_aligned(alu_in[1:0]);
  assign w_start   = r_state == IDLE && w_access && w_aligned;
  assign stall     = w_start || r_state == REQ;
  assign alu_out   = alu_in;
  assign wn_out    = wn_in;
  // Misaligned accesses and timed-out accesses must not write back.
  assign wb_out    = (r_state == IDLE && w_access && !w_aligned) || (r_state == DONE && bus_err) ? 2'b00 : wb_in;
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == REQ),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      rd_out         <= '0;
      misalign       <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      misalign <= r_state == IDLE && w_access && !w_aligned;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE:
          if (w_start) begin
            bus.dmem_addr  <= alu_in;
            bus.dmem_wdata <= wdata_in;
            bus.dmem_we    <= mem_write;
            bus.dmem_req   <= 1'b1;
            r_state        <= REQ;
          end
        REQ:
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (!bus.dmem_we) rd_out <= bus.dmem_rdata;
            r_state <= DONE;
          end else if (w_expired) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus_err      <= 1'b1;
            rd_out       <= '0;
            r_state      <= DONE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipelined MIPS-Lite CPU. Sits between the EX/MEM pipeline register and MEM_WB.
- Performs loads and stores against a data memory through a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Presents read data, ALU result, write-register number and WB control bits to MEM_WB, which captures them on every non-stalled cycle.

Parameters:
- DATA_W, 32, width of data and address.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock; all state updates on posedge clk.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  load request from EX/MEM M field.
- mem_write  in  1  store request from EX/MEM M field.
- alu_in  in  DATA_W  ALU result; used as byte address.
- wdata_in  in  DATA_W  store data.
- wn_in  in  5  destination register number.
- wb_in  in  2  {MemtoReg, RegWrite}.
- rd_out  out  DATA_W  load data, to MEM_WB RD_in.
- alu_out  out  DATA_W  pass-through of alu_in.
- wn_out  out  5  pass-through of wn_in.
- wb_out  out  2  wb_in, or 2'b00 when suppressed.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM, and holds MEM_WB.
- misalign  out  1  one-cycle pulse when the access address is not word aligned.
- bus_err  out  1  one-cycle pulse on timeout abort.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  word-aligned address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack.
- dmem_ack  in  1  one-cycle completion strobe.

Behaviour:
- Reset: state=IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, rd_out, misalign and bus_err are all 0.
- Pass-through outputs (alu_out, wn_out, wb_out) are combinational from the inputs. EX/MEM is frozen by stall, so they stay stable for the whole access.
- access = mem_read | mem_write. If both are asserted, the write wins (dmem_we=1) and rd_out is unchanged.
- aligned = (alu_in[1:0]==2'b00).
- FSM states:
  - IDLE:
    - access & aligned: register dmem_addr=alu_in, dmem_wdata=wdata_in, dmem_we=mem_write; set dmem_req=1; go to REQ.
    - access & !aligned: no request; misalign=1 next cycle; wb_out=2'b00 this cycle; remain in IDLE.
    - No access: remain in IDLE.
  - REQ: hold dmem_req and all dmem_* outputs stable until dmem_ack. On ack: dmem_req=0; rd_out<=dmem_rdata if it was a read; go to DONE.
  - DONE: stall=0 for exactly one cycle so MEM_WB captures; next state is IDLE.
- stall = (IDLE & access & aligned) | REQ. It is 0 in DONE and for non-memory instructions.
- Minimum access latency: 2 stall cycles (ack arriving on the first REQ cycle). Each additional ack wait cycle adds one stall cycle.
- rd_out holds its last value for non-load instructions.
- dmem_ack outside REQ is ignored.
- rst in any state returns the FSM to IDLE on the next edge and drops dmem_req. A late ack arriving afterwards is ignored.
- Back-to-back memory instructions: the DONE cycle advances the pipeline. The next instruction is seen in IDLE on the following cycle, so no request is issued during DONE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter counts cycles spent in REQ.
  - On reaching TIMEOUT_CYCLES with no ack: drop dmem_req, pulse bus_err, set rd_out=0, go to DONE, and force wb_out=2'b00 during that DONE cycle.
- Undefined: REQ waits indefinitely, bus_err is tied to 0, and no counter logic is present.

Decomposition:
- Shared package mips_lite_pkg: FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), WB bit indices (WB_MEMTOREG=1, WB_REGWRITE=0), WORD_ALIGN_MASK=2'b11.
- One natural sub-module: mem_timeout_ctr. It holds the saturating REQ-cycle counter and is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load, ack after 3 cycles: mem_read=1, alu_in=0x100, dmem_rdata=0xDEADBEEF. Required: dmem_req high for 3 cycles with dmem_addr=0x100, stall high for 4 cycles, rd_out=0xDEADBEEF in DONE, wb_out=wb_in.
- Store, immediate ack: mem_write=1, alu_in=0x20, wdata_in=0x12345678. Required: dmem_we=1 and dmem_wdata=0x12345678 for one cycle, stall high for exactly 2 cycles, rd_out unchanged.
- Misaligned load: alu_in=0x102 with mem_read=1. Required: no dmem_req, stall=0, wb_out=2'b00, misalign pulses for 1 cycle.
- Reset mid-access: rst asserted in REQ, then ack 2 cycles later. Required: state IDLE, dmem_req=0 next cycle, rd_out=0, late ack ignored.
- Back-to-back loads to 0x0 then 0x4, each acked after 1 cycle. Required: two separate requests separated by a DONE cycle with stall=0, and rd_out correct for each.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never returned. Required: dmem_req drops after 16 REQ cycles, bus_err pulses once, rd_out=0, wb_out=2'b00 in DONE.
